rx_iq_scheduler: RTL and testbench
==================================

Name: rx_iq_scheduler

Overview:
- Buffers decimated RX1/RX2 IQ samples from the DDC chains into one interleaved FIFO.
- Serves entries one at a time to the STM32 parallel-bus interface on its RX IQ read request.
- Arbitrates simultaneous RX1/RX2 strobes and reports overrun/underrun.
- Sits between the DDC outputs and the bus interface, in the bus clock domain.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 4.
- SAMPLE_W, 24, width of each I and Q sample.

Ports:
- clk_in  in  1  bus/system clock
- reset_in  in  1  synchronous reset, active-high
- rx1_enable  in  1  RX1 stream enabled
- rx2_enable  in  1  RX2 stream enabled
- rx1_i, rx1_q  in  SAMPLE_W each  RX1 sample, signed
- rx1_valid  in  1  one-cycle strobe: new RX1 sample
- rx2_i, rx2_q  in  SAMPLE_W each  RX2 sample, signed
- rx2_valid  in  1  one-cycle strobe: new RX2 sample
- read_req  in  1  one-cycle pop request from the bus interface
- flush  in  1  one-cycle strobe: discard all buffered data
- overrun_clear  in  1  clears the sticky overrun flag
- out_i, out_q  out  SAMPLE_W each  popped sample
- out_chan  out  1  0 = RX1, 1 = RX2
- out_valid  out  1  one-cycle pulse: out_* updated
- underrun  out  1  one-cycle pulse: read_req arrived while empty
- empty  out  1  FIFO holds no entries
- fill  out  clog2(DEPTH)+1  current entry count
- overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset: out_i = out_q = 0, out_chan = 0, out_valid = 0, underrun = 0, empty = 1, fill = 0, overrun = 0; FIFO pointers zeroed; arbiter in ARB_IDLE; pending register cleared.
- Entry format is {chan, I, Q}, 2*SAMPLE_W+1 bits.
- A strobe whose channel enable is 0 is ignored entirely.
- Arbiter states:
  - ARB_IDLE: rx1_valid alone pushes RX1. rx2_valid alone pushes RX2. Both together push RX1, capture RX2 into the pending register, and go to ARB_PEND.
  - ARB_PEND: the pending RX2 entry is pushed this cycle; return to ARB_IDLE. If rx1_valid also arrives, it is captured into the pending register and pushed next cycle (stay in ARB_PEND). A rx2_valid arriving in ARB_PEND is dropped and sets overrun.
  - rx2_enable falling in ARB_PEND discards the pending entry; go to ARB_IDLE.
- Push while full (fill == DEPTH and no simultaneous pop) drops the new entry and sets overrun. The existing contents are never overwritten.
- Pop: on read_req with fill > 0, out_i/out_q/out_chan load the head entry on the next clock edge, with out_valid high for exactly that one cycle. Latency is 1 cycle. Outputs hold until the next pop.
- read_req with fill == 0: the underrun pulse fires on the next cycle, out_* are unchanged and out_valid stays 0. overrun is not affected.
- Push and pop in the same cycle: both proceed and fill is unchanged. When full, this push is accepted, not dropped.
- Push into an empty FIFO with read_req in the same cycle is treated as empty: the result is underrun, and the entry stays in the FIFO.
- Pointers wrap modulo DEPTH. fill is in the range 0..DEPTH.
- flush: pointers, fill and pending are cleared and the arbiter goes to ARB_IDLE. A push or pop in that same cycle is ignored. overrun is unchanged.
- overrun_clear clears the flag. If a drop occurs in the same cycle, set wins.
- reset_in mid-operation behaves exactly as the reset state above. No partial entries are kept.

Decomposition:
- Shared package rx_iq_pkg holds:
  - CHAN_RX1 = 0, CHAN_RX2 = 1
  - the entry-width constant (2*SAMPLE_W+1)
  - the arbiter state enum {ARB_IDLE, ARB_PEND}
- Sub-module iq_sync_fifo: a single-clock FIFO with registered read, full/empty/count outputs and push/pop/flush inputs. The scheduler contains only the arbiter, the pending register and the flags.

Test Plan:
- Reset, then rx1_valid with I=0x000123, Q=0xFFFF00, then read_req -> one cycle later out_valid=1, out_chan=0, out_i=0x000123, out_q=0xFFFF00, fill 1->0, empty=1.
- rx1_valid and rx2_valid in the same cycle (I=1 and I=2), then two read_req -> pops return chan 0 with I=1, then chan 1 with I=2. fill peaks at 2 one cycle after the strobes.
- Push 16 RX1 samples (I=0..15) with DEPTH=16, then one more (I=16) -> overrun=1, fill=16. Sixteen pops return I=0..15 in order; the 17th read_req gives underrun=1 and no out_valid.
- Fill to 16, then issue push (I=99) and read_req in the same cycle -> no overrun, fill stays 16, popped I=0, and the last of the next 16 pops returns I=99.
- rx2_enable=0 with rx2_valid strobes -> fill stays 0. With both valids, then rx2_enable dropped while in ARB_PEND -> only the RX1 entry is stored.
- Fill to 5, then pulse flush together with rx1_valid -> fill=0, empty=1, overrun unchanged. Assert overrun_clear in the same cycle as a drop -> overrun stays 1.

Source files
------------

// File: rtl/rx_iq_scheduler_pkg.sv
// Shared constants and types for the RX IQ scheduler: channel codes, entry width, arbiter states.
package rx_iq_pkg;

  localparam logic CHAN_RX1 = 1'b0;
  localparam logic CHAN_RX2 = 1'b1;

  localparam int SAMPLE_W_DEFAULT = 24;

  // Entry layout is {chan, I, Q}
  function automatic int entry_w(input int sample_w);
    return 2 * sample_w + 1;
  endfunction

  localparam int ENTRY_W_DEFAULT = entry_w(SAMPLE_W_DEFAULT);

  typedef enum logic {
    ARB_IDLE,
    ARB_PEND
  } arb_state_e;

endpackage

// File: rtl/rx_iq_scheduler_if.sv
// DDC-side sample strobes, bus-side pop request and popped-sample outputs of the RX IQ scheduler.
interface rx_iq_scheduler_if #(
  parameter int SAMPLE_W = 24,
  parameter int DEPTH    = 16
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic                       rx1_enable;
  logic                       rx2_enable;
  logic signed [SAMPLE_W-1:0] rx1_i;
  logic signed [SAMPLE_W-1:0] rx1_q;
  logic                       rx1_valid;
  logic signed [SAMPLE_W-1:0] rx2_i;
  logic signed [SAMPLE_W-1:0] rx2_q;
  logic                       rx2_valid;
  logic                       read_req;
  logic                       flush;
  logic                       overrun_clear;
  logic signed [SAMPLE_W-1:0] out_i;
  logic signed [SAMPLE_W-1:0] out_q;
  logic                       out_chan;
  logic                       out_valid;
  logic                       underrun;
  logic                       empty;
  logic [FILL_W-1:0]          fill;
  logic                       overrun;

  modport master (
    output rx1_enable, rx2_enable, rx1_i, rx1_q, rx1_valid,
           rx2_i, rx2_q, rx2_valid, read_req, flush, overrun_clear,
    input  out_i, out_q, out_chan, out_valid, underrun, empty, fill, overrun
  );

  modport slave (
    input  rx1_enable, rx2_enable, rx1_i, rx1_q, rx1_valid,
           rx2_i, rx2_q, rx2_valid, read_req, flush, overrun_clear,
    output out_i, out_q, out_chan, out_valid, underrun, empty, fill, overrun
  );

endinterface

// File: rtl/rx_iq_scheduler_fifo.sv
// Single-clock FIFO with registered read port; push into full is refused unless a pop is accepted
// the same cycle, pop from empty is refused, flush clears pointers and ignores that cycle's push/pop.
module iq_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 49
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_dat_o,
  output logic                   rd_vld_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_dat_q;
  logic             rd_vld_q;
  logic             pop_ok, push_ok;

  assign full_o   = (count_q == FULL_CNT);
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rd_dat_o = rd_dat_q;
  assign rd_vld_o = rd_vld_q;

  always_comb begin
    pop_ok   = pop_i && !flush_i && !empty_o;
    push_ok  = push_i && !flush_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok) count_d = count_q + CNT_ONE;
      if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_vld_q <= pop_ok;
      if (pop_ok) rd_dat_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/rx_iq_scheduler.sv
// Merges RX1/RX2 DDC sample strobes into one interleaved FIFO served to the bus on read_req.
// RX1 wins a simultaneous strobe; RX2 waits one cycle in a pending register.
module rx_iq_scheduler
  import rx_iq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 24
) (
  input  logic          clk_in,
  input  logic          reset_in,
  rx_iq_scheduler_if.slave bus
);
  localparam int ENTRY_W = entry_w(SAMPLE_W);
  localparam int FILL_W  = $clog2(DEPTH) + 1;

  arb_state_e         state_q;
  logic [ENTRY_W-1:0] pend_q;
  logic               overrun_q, overrun_d;
  logic               underrun_q, underrun_d;

  logic               v1, v2;
  logic [ENTRY_W-1:0] rx1_ent, rx2_ent;
  logic               pend_kill;
  logic               push;
  logic [ENTRY_W-1:0] push_dat;
  logic               arb_drop, fifo_drop;

  logic [ENTRY_W-1:0] rd_dat;
  logic               rd_vld;
  logic               fifo_full, fifo_empty;
  logic [FILL_W-1:0]  fifo_count;

  assign v1      = bus.rx1_valid && bus.rx1_enable;
  assign v2      = bus.rx2_valid && bus.rx2_enable;
  assign rx1_ent = {CHAN_RX1, bus.rx1_i, bus.rx1_q};
  assign rx2_ent = {CHAN_RX2, bus.rx2_i, bus.rx2_q};

  // Only a held RX2 sample is discarded when RX2 is disabled; a held RX1 sample is still delivered.
  assign pend_kill = (state_q == ARB_PEND) && !bus.rx2_enable && (pend_q[ENTRY_W-1] == CHAN_RX2);

  always_comb begin
    push     = 1'b0;
    push_dat = rx1_ent;
    arb_drop = 1'b0;
    if (state_q == ARB_IDLE || pend_kill) begin
      if (v1) begin
        push     = 1'b1;
        push_dat = rx1_ent;
      end else if (v2) begin
        push     = 1'b1;
        push_dat = rx2_ent;
      end
    end else begin
      push     = 1'b1;
      push_dat = pend_q;
      arb_drop = v2;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in || bus.flush) begin
      state_q <= ARB_IDLE;
      pend_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (v1 && v2) begin
            pend_q  <= rx2_ent;
            state_q <= ARB_PEND;
          end
        end
        ARB_PEND: begin
          if (!pend_kill && v1) pend_q <= rx1_ent;
          else                  state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  iq_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i      (clk_in),
    .rst_i      (reset_in),
    .flush_i    (bus.flush),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (bus.read_req),
    .rd_dat_o   (rd_dat),
    .rd_vld_o   (rd_vld),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign fifo_drop = push && !bus.flush && fifo_full && !(bus.read_req && !fifo_empty);

  always_comb begin
    underrun_d = bus.read_req && fifo_empty && !bus.flush;
    overrun_d  = overrun_q;
    if (bus.overrun_clear) overrun_d = 1'b0;
    if ((fifo_drop || arb_drop) && !bus.flush) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.out_chan  = rd_dat[ENTRY_W-1];
  assign bus.out_i     = rd_dat[ENTRY_W-2 -: SAMPLE_W];
  assign bus.out_q     = rd_dat[SAMPLE_W-1:0];
  assign bus.out_valid = rd_vld;
  assign bus.underrun  = underrun_q;
  assign bus.empty     = fifo_empty;
  assign bus.fill      = fifo_count;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_rx_iq_scheduler.sv
// Directed bench for rx_iq_scheduler: expected pops/underruns are queued at each read_req and
// compared by a monitor whenever out_valid or underrun is seen; levels are checked inline.
module tb_rx_iq_scheduler;

  logic clk_in = 1'b0;
  logic reset_in;
  always #5 clk_in = ~clk_in;

  rx_iq_scheduler_if #(.SAMPLE_W(24), .DEPTH(16)) bus ();

  rx_iq_scheduler #(.DEPTH(16), .SAMPLE_W(24)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  typedef struct {
    logic        und;
    logic        chan;
    logic [23:0] i;
    logic [23:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clk_in) begin
    if (!reset_in && (bus.out_valid || bus.underrun)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: valid=%0b underrun=%0b chan=%0d i=%h", bus.out_valid,
                 bus.underrun, bus.out_chan, bus.out_i);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.underrun !== e.und || bus.out_valid !== !e.und ||
            (!e.und && (bus.out_chan !== e.chan || bus.out_i !== e.i || bus.out_q !== e.q))) begin
          failures++;
          $display("FAIL pop: got valid=%0b und=%0b chan=%0d i=%h q=%h, expected und=%0b chan=%0d i=%h q=%h",
                   bus.out_valid, bus.underrun, bus.out_chan, bus.out_i, bus.out_q,
                   e.und, e.chan, e.i, e.q);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    bus.rx1_valid     = 1'b0;
    bus.rx2_valid     = 1'b0;
    bus.read_req      = 1'b0;
    bus.flush         = 1'b0;
    bus.overrun_clear = 1'b0;
  endtask

  task automatic set1(input logic [23:0] i, input logic [23:0] q);
    bus.rx1_i = i; bus.rx1_q = q; bus.rx1_valid = 1'b1;
  endtask

  task automatic set2(input logic [23:0] i, input logic [23:0] q);
    bus.rx2_i = i; bus.rx2_q = q; bus.rx2_valid = 1'b1;
  endtask

  task automatic expect_pop(input logic und, input logic chan, input logic [23:0] i,
                            input logic [23:0] q);
    exp_t e;
    e.und = und; e.chan = chan; e.i = i; e.q = q;
    exp_q.push_back(e);
    bus.read_req = 1'b1;
  endtask

  task automatic push1(input logic [23:0] i, input logic [23:0] q);
    set1(i, q);
    tick();
  endtask

  task automatic rd(input logic und, input logic chan, input logic [23:0] i, input logic [23:0] q);
    expect_pop(und, chan, i, q);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1;
    bus.rx1_enable = 1'b0; bus.rx2_enable = 1'b0;
    bus.rx1_i = '0; bus.rx1_q = '0; bus.rx2_i = '0; bus.rx2_q = '0;
    bus.rx1_valid = 1'b0; bus.rx2_valid = 1'b0;
    bus.read_req = 1'b0; bus.flush = 1'b0; bus.overrun_clear = 1'b0;
    tick(); tick();
    reset_in = 1'b0;
    tick();
    chk("rst_out_i", int'(bus.out_i), 0);
    chk("rst_out_chan", int'(bus.out_chan), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_underrun", int'(bus.underrun), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_fill", int'(bus.fill), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    bus.rx1_enable = 1'b1; bus.rx2_enable = 1'b1;

    // single RX1 sample round trip
    push1(24'h000123, 24'hFFFF00);
    chk("t1_fill_after_push", int'(bus.fill), 1);
    chk("t1_empty_after_push", int'(bus.empty), 0);
    rd(1'b0, 1'b0, 24'h000123, 24'hFFFF00);
    chk("t1_fill_after_pop", int'(bus.fill), 0);
    chk("t1_empty_after_pop", int'(bus.empty), 1);

    // simultaneous strobes: RX1 first, RX2 a cycle later
    set1(24'd1, 24'd0); set2(24'd2, 24'd0);
    tick();
    chk("t2_fill_strobe", int'(bus.fill), 1);
    tick();
    chk("t2_fill_peak", int'(bus.fill), 2);
    rd(1'b0, 1'b0, 24'd1, 24'd0);
    rd(1'b0, 1'b1, 24'd2, 24'd0);
    chk("t2_fill_end", int'(bus.fill), 0);

    // fill to full, one dropped push, drain, underrun
    for (int k = 0; k < 16; k++) push1(24'(k), 24'd0);
    chk("t3_fill_full", int'(bus.fill), 16);
    chk("t3_no_overrun_yet", int'(bus.overrun), 0);
    push1(24'd16, 24'd0);
    chk("t3_overrun", int'(bus.overrun), 1);
    chk("t3_fill_held", int'(bus.fill), 16);
    for (int k = 0; k < 16; k++) rd(1'b0, 1'b0, 24'(k), 24'd0);
    rd(1'b1, 1'b0, 24'd0, 24'd0);
    chk("t3_fill_drained", int'(bus.fill), 0);
    bus.overrun_clear = 1'b1;
    tick();
    chk("t3_overrun_cleared", int'(bus.overrun), 0);

    // push and pop together while full
    for (int k = 0; k < 16; k++) push1(24'(k), 24'd0);
    set1(24'd99, 24'd0);
    expect_pop(1'b0, 1'b0, 24'd0, 24'd0);
    tick();
    chk("t4_fill_full_pushpop", int'(bus.fill), 16);
    chk("t4_no_overrun", int'(bus.overrun), 0);
    for (int k = 1; k < 16; k++) rd(1'b0, 1'b0, 24'(k), 24'd0);
    rd(1'b0, 1'b0, 24'd99, 24'd0);
    chk("t4_fill_end", int'(bus.fill), 0);

    // disabled RX2 strobes are ignored
    bus.rx2_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set2(24'(k + 40), 24'd0);
      tick();
    end
    chk("t5_rx2_disabled_fill", int'(bus.fill), 0);
    bus.rx2_enable = 1'b1;
    // RX2 disabled while pending: only RX1 kept
    set1(24'd5, 24'd0); set2(24'd6, 24'd0);
    tick();
    bus.rx2_enable = 1'b0;
    tick();
    tick();
    chk("t5_pend_kill_fill", int'(bus.fill), 1);
    bus.rx2_enable = 1'b1;
    rd(1'b0, 1'b0, 24'd5, 24'd0);
    // RX1 arriving while RX2 pending is held and pushed next
    set1(24'd7, 24'h7); set2(24'd8, 24'h8);
    tick();
    set1(24'd9, 24'h9);
    tick();
    tick();
    chk("t5_pend_rx1_fill", int'(bus.fill), 3);
    rd(1'b0, 1'b0, 24'd7, 24'h7);
    rd(1'b0, 1'b1, 24'd8, 24'h8);
    rd(1'b0, 1'b0, 24'd9, 24'h9);
    // RX2 arriving while RX2 pending is dropped
    set1(24'd10, 24'd0); set2(24'd11, 24'd0);
    tick();
    set2(24'd12, 24'd0);
    tick();
    chk("t5_pend_drop_overrun", int'(bus.overrun), 1);
    chk("t5_pend_drop_fill", int'(bus.fill), 2);
    rd(1'b0, 1'b0, 24'd10, 24'd0);
    rd(1'b0, 1'b1, 24'd11, 24'd0);
    bus.overrun_clear = 1'b1;
    tick();

    // clear and drop in the same cycle: set wins
    for (int k = 0; k < 16; k++) push1(24'(k), 24'd0);
    set1(24'd200, 24'd0);
    bus.overrun_clear = 1'b1;
    tick();
    chk("t6_set_wins", int'(bus.overrun), 1);
    bus.flush = 1'b1;
    tick();
    chk("t6_flush_fill", int'(bus.fill), 0);
    for (int k = 0; k < 5; k++) push1(24'(k + 60), 24'd0);
    chk("t6_fill5", int'(bus.fill), 5);
    set1(24'd50, 24'd0);
    bus.flush = 1'b1;
    tick();
    chk("t6_flush_push_fill", int'(bus.fill), 0);
    chk("t6_flush_empty", int'(bus.empty), 1);
    chk("t6_flush_overrun_kept", int'(bus.overrun), 1);
    rd(1'b1, 1'b0, 24'd0, 24'd0);
    bus.overrun_clear = 1'b1;
    tick();
    chk("t6_overrun_cleared", int'(bus.overrun), 0);

    // push into empty with read_req: underrun, entry retained
    set1(24'd77, 24'd0);
    expect_pop(1'b1, 1'b0, 24'd0, 24'd0);
    tick();
    chk("t7_entry_kept", int'(bus.fill), 1);
    rd(1'b0, 1'b0, 24'd77, 24'd0);
    chk("t7_fill_end", int'(bus.fill), 0);

    // reset mid-operation
    for (int k = 0; k < 3; k++) push1(24'(k + 80), 24'd0);
    for (int k = 0; k < 16; k++) push1(24'(k), 24'd0);
    chk("t8_overrun_before_reset", int'(bus.overrun), 1);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    chk("t8_reset_fill", int'(bus.fill), 0);
    chk("t8_reset_empty", int'(bus.empty), 1);
    chk("t8_reset_overrun", int'(bus.overrun), 0);
    rd(1'b1, 1'b0, 24'd0, 24'd0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    tick();
    chk("drain_outstanding", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
